alu_dispatch_unit: RTL and testbench

//  In-order dispatcher feeding the issue buffers: accepts fetched instructions, tags each with a
//  32-bit instruction number, and classifies it as ALU or branch. It then writes it over the

---
 rtl/alu_dispatch_unit.sv | 187 ++++++++++++++++++
 tb/tb_alu_dispatch_unit.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_dispatch_unit.sv
// -----------------------------------------------------------------------------
// alu_dispatch_unit
//
// In-order dispatcher between instruction fetch and the ALU / branch issue
// buffers. Fetched words are queued, tagged with a running 32-bit instruction
// number and, once they reach the head of the queue, classified by opcode and
// written to either the ALU buffer or the branch buffer. A transfer is signalled
// with a one-cycle DR strobe. All-zero words (NOPs) are discarded on entry and
// consume no number.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   IF_Instr, IF_Valid, IF_Ready     fetch side valid/ready handshake
//   flush                            drop every queued, undispatched word
//   ALUbuffer_ready, ALU_Instr,
//   ALU_InstrNO, ALU_DR              ALU issue buffer write port
//   BRbuffer_ready, BR_Instr,
//   BR_InstrNO, BR_DR                branch issue buffer write port
//   q_level                          current queue occupancy
// -----------------------------------------------------------------------------
module alu_dispatch_unit #(
    parameter int          DEPTH        = 8,
    parameter logic [31:0] INSTRNO_BASE = 32'd1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [31:0]              IF_Instr,
    input  logic                     IF_Valid,
    output logic                     IF_Ready,
    input  logic                     flush,
    input  logic                     ALUbuffer_ready,
    output logic [31:0]              ALU_Instr,
    output logic [31:0]              ALU_InstrNO,
    output logic                     ALU_DR,
    input  logic                     BRbuffer_ready,
    output logic [31:0]              BR_Instr,
    output logic [31:0]              BR_InstrNO,
    output logic                     BR_DR,
    output logic [$clog2(DEPTH):0]   q_level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    // Opcodes that execute in the ALU; everything else goes to the branch unit.
    function automatic logic is_alu_op(input logic [5:0] op);
        case (op)
            6'b000000, 6'b001000, 6'b001001, 6'b000110, 6'b001011,
            6'b001100, 6'b001101, 6'b001110, 6'b001111, 6'b101011,
            6'b100011: return 1'b1;
            default:   return 1'b0;
        endcase
    endfunction

    // Queue storage
    logic [31:0] instr_mem_q [DEPTH];
    logic [31:0] no_mem_q    [DEPTH];

    // Control state
    logic [PW-1:0] wr_ptr_q,  wr_ptr_d;
    logic [PW-1:0] rd_ptr_q,  rd_ptr_d;
    logic [LW-1:0] level_q,   level_d;
    logic [31:0]   next_no_q, next_no_d;
    logic          alive_q;   // low during reset, high from the first edge after release

    // Output registers
    logic [31:0]   alu_instr_q, alu_instr_d;
    logic [31:0]   alu_no_q,    alu_no_d;
    logic          alu_dr_q,    alu_dr_d;
    logic [31:0]   br_instr_q,  br_instr_d;
    logic [31:0]   br_no_q,     br_no_d;
    logic          br_dr_q,     br_dr_d;

    logic [31:0]   head_instr;
    logic [31:0]   head_no;
    logic          head_valid;
    logic          head_is_alu;
    logic          head_tgt_ready;
    logic          push;
    logic          pop;

    assign IF_Ready = alive_q & (level_q < LW'(DEPTH));

    // Head is taken from registered state only, so a word pushed into an empty
    // queue cannot leave on the same edge it arrives.
    assign head_valid     = (level_q != '0);
    assign head_instr     = instr_mem_q[rd_ptr_q];
    assign head_no        = no_mem_q[rd_ptr_q];
    assign head_is_alu    = is_alu_op(head_instr[31:26]);
    assign head_tgt_ready = head_is_alu ? ALUbuffer_ready : BRbuffer_ready;

    // A flush suppresses both the fetch transfer and the dispatch on its edge.
    assign push = IF_Valid & IF_Ready & ~flush & (IF_Instr != 32'h0000_0000);
    assign pop  = head_valid & head_tgt_ready & ~flush;

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        next_no_d   = next_no_q;
        alu_instr_d = alu_instr_q;
        alu_no_d    = alu_no_q;
        alu_dr_d    = 1'b0;
        br_instr_d  = br_instr_q;
        br_no_d     = br_no_q;
        br_dr_d     = 1'b0;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d  = wr_ptr_q + PW'(1);
                next_no_d = next_no_q + 32'd1;   // wraps FFFFFFFF -> 0
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
                // Port data changes only together with a new DR strobe.
                if (head_is_alu) begin
                    alu_instr_d = head_instr;
                    alu_no_d    = head_no;
                    alu_dr_d    = 1'b1;
                end else begin
                    br_instr_d  = head_instr;
                    br_no_d     = head_no;
                    br_dr_d     = 1'b1;
                end
            end
            case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            next_no_q   <= INSTRNO_BASE;
            alive_q     <= 1'b0;
            alu_instr_q <= '0;
            alu_no_q    <= '0;
            alu_dr_q    <= 1'b0;
            br_instr_q  <= '0;
            br_no_q     <= '0;
            br_dr_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            next_no_q   <= next_no_d;
            alive_q     <= 1'b1;
            alu_instr_q <= alu_instr_d;
            alu_no_q    <= alu_no_d;
            alu_dr_q    <= alu_dr_d;
            br_instr_q  <= br_instr_d;
            br_no_q     <= br_no_d;
            br_dr_q     <= br_dr_d;
        end
    end

    // NOTE: queue storage has no reset; an entry is only ever read after it was
    // written, and occupancy is tracked by the reset-controlled level/pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= IF_Instr;
            no_mem_q[wr_ptr_q]    <= next_no_q;
        end
    end

    assign ALU_Instr   = alu_instr_q;
    assign ALU_InstrNO = alu_no_q;
    assign ALU_DR      = alu_dr_q;
    assign BR_Instr    = br_instr_q;
    assign BR_InstrNO  = br_no_q;
    assign BR_DR       = br_dr_q;
    assign q_level     = level_q;

endmodule

// File: tb/tb_alu_dispatch_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_dispatch_unit
//
// Scoreboard bench for alu_dispatch_unit. Stimulus tasks push the hand-written
// expected (port, word, number) of every word that must reach a buffer; monitor
// processes pop and compare whenever a DR strobe is seen. A second instance with
// INSTRNO_BASE = FFFFFFFF covers number wrap-around.
// -----------------------------------------------------------------------------
module tb_alu_dispatch_unit;

    typedef struct {
        bit          is_br;
        logic [31:0] instr;
        logic [31:0] no;
    } exp_t;

    localparam logic [31:0] W_ADD = 32'h012A_4020;  // opcode 000000 -> ALU
    localparam logic [31:0] W_BEQ = 32'h1109_0003;  // opcode 000100 -> branch
    localparam logic [31:0] W_LW  = 32'h8C22_0004;  // opcode 100011 -> ALU

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] IF_Instr = '0;
    logic        IF_Valid = 1'b0;
    logic        IF_Ready;
    logic        flush = 1'b0;
    logic        ALUbuffer_ready = 1'b0;
    logic [31:0] ALU_Instr, ALU_InstrNO;
    logic        ALU_DR;
    logic        BRbuffer_ready = 1'b0;
    logic [31:0] BR_Instr, BR_InstrNO;
    logic        BR_DR;
    logic [3:0]  q_level;

    // Wrap-around instance
    logic [31:0] IF_Instr1 = '0;
    logic        IF_Valid1 = 1'b0;
    logic        IF_Ready1;
    logic [31:0] ALU_Instr1, ALU_InstrNO1, BR_Instr1, BR_InstrNO1;
    logic        ALU_DR1, BR_DR1;
    logic [3:0]  q_level1;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb[$];
    exp_t sb1[$];

    always #5 clk = ~clk;

    alu_dispatch_unit #(.DEPTH(8), .INSTRNO_BASE(32'd1)) dut (
        .clk(clk), .rst_n(rst_n),
        .IF_Instr(IF_Instr), .IF_Valid(IF_Valid), .IF_Ready(IF_Ready),
        .flush(flush),
        .ALUbuffer_ready(ALUbuffer_ready), .ALU_Instr(ALU_Instr),
        .ALU_InstrNO(ALU_InstrNO), .ALU_DR(ALU_DR),
        .BRbuffer_ready(BRbuffer_ready), .BR_Instr(BR_Instr),
        .BR_InstrNO(BR_InstrNO), .BR_DR(BR_DR),
        .q_level(q_level)
    );

    alu_dispatch_unit #(.DEPTH(8), .INSTRNO_BASE(32'hFFFF_FFFF)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .IF_Instr(IF_Instr1), .IF_Valid(IF_Valid1), .IF_Ready(IF_Ready1),
        .flush(1'b0),
        .ALUbuffer_ready(1'b1), .ALU_Instr(ALU_Instr1),
        .ALU_InstrNO(ALU_InstrNO1), .ALU_DR(ALU_DR1),
        .BRbuffer_ready(1'b1), .BR_Instr(BR_Instr1),
        .BR_InstrNO(BR_InstrNO1), .BR_DR(BR_DR1),
        .q_level(q_level1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor for the main instance: order, port, word and number of every
    // strobe, plus data stability while no strobe is present.
    logic [31:0] alu_last_i = '0, alu_last_n = '0, br_last_i = '0, br_last_n = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            alu_last_i = '0; alu_last_n = '0; br_last_i = '0; br_last_n = '0;
        end else begin
            if (ALU_DR && BR_DR) check("dual_dr", 32'd1, 32'd0);
            if (ALU_DR) begin
                if (sb.size() == 0) check("spurious_alu_dr", 32'd1, 32'd0);
                else begin
                    e = sb.pop_front();
                    check("alu_port", {31'd0, e.is_br}, 32'd0);
                    check("alu_instr", ALU_Instr, e.instr);
                    check("alu_instrno", ALU_InstrNO, e.no);
                end
                alu_last_i = ALU_Instr; alu_last_n = ALU_InstrNO;
            end else begin
                check("alu_hold_instr", ALU_Instr, alu_last_i);
                check("alu_hold_no", ALU_InstrNO, alu_last_n);
            end
            if (BR_DR) begin
                if (sb.size() == 0) check("spurious_br_dr", 32'd1, 32'd0);
                else begin
                    e = sb.pop_front();
                    check("br_port", {31'd0, e.is_br}, 32'd1);
                    check("br_instr", BR_Instr, e.instr);
                    check("br_instrno", BR_InstrNO, e.no);
                end
                br_last_i = BR_Instr; br_last_n = BR_InstrNO;
            end else begin
                check("br_hold_instr", BR_Instr, br_last_i);
                check("br_hold_no", BR_InstrNO, br_last_n);
            end
        end
    end

    // Monitor for the wrap-around instance
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (ALU_DR1 || BR_DR1)) begin
            if (sb1.size() == 0) check("wrap_spurious_dr", 32'd1, 32'd0);
            else begin
                e = sb1.pop_front();
                check("wrap_port", {31'd0, BR_DR1}, {31'd0, e.is_br});
                check("wrap_instr", BR_DR1 ? BR_Instr1 : ALU_Instr1, e.instr);
                check("wrap_instrno", BR_DR1 ? BR_InstrNO1 : ALU_InstrNO1, e.no);
            end
        end
    end

    // Offer one word; queue its expectation only if it must reach a buffer.
    task automatic push(input logic [31:0] w, input bit is_br,
                        input logic [31:0] no, input bit exp);
        int waited = 0;
        IF_Instr = w;
        IF_Valid = 1'b1;
        while (!IF_Ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!IF_Ready) begin
            check("push_timeout", 32'd0, 32'd1);
            IF_Valid = 1'b0;
            return;
        end
        if (exp) sb.push_back('{is_br, w, no});
        tick();
        IF_Valid = 1'b0;
    endtask

    // Wait until the scoreboard is empty; returns negedges spent.
    task automatic wait_drain(output int cyc);
        cyc = 0;
        while (sb.size() != 0 && cyc < 50) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("drain_left", sb.size(), 32'd0);
    endtask

    task automatic rst_assert();
        rst_n = 1'b0;
        IF_Valid = 1'b0;
        flush = 1'b0;
        sb.delete();
        sb1.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic rst_release();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", {31'd0, IF_Ready}, 32'd0);
        tick();
        check("ready_after_release", {31'd0, IF_Ready}, 32'd1);
        check("level_after_release", {28'd0, q_level}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;

        // T1: reset while ALU_DR is high, with a second word still queued
        rst_assert();
        check("rst_alu_dr", {31'd0, ALU_DR}, 32'd0);
        check("rst_ready", {31'd0, IF_Ready}, 32'd0);
        rst_release();
        ALUbuffer_ready = 1'b1;
        push(W_ADD, 1'b0, 32'd1, 1'b1);
        push(W_LW,  1'b0, 32'd2, 1'b0);
        @(negedge clk);
        #1;
        check("t1_dr_high", {31'd0, ALU_DR}, 32'd1);
        check("t1_level_before", {28'd0, q_level}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t1_alu_dr_async", {31'd0, ALU_DR}, 32'd0);
        check("t1_br_dr_async", {31'd0, BR_DR}, 32'd0);
        check("t1_level_async", {28'd0, q_level}, 32'd0);
        check("t1_ready_async", {31'd0, IF_Ready}, 32'd0);
        check("t1_instr_async", ALU_Instr, 32'd0);
        rst_assert();
        rst_release();

        // T2: single ALU word gets number 1
        ALUbuffer_ready = 1'b1;
        push(W_ADD, 1'b0, 32'd1, 1'b1);
        wait_drain(cyc);

        // T3: branch blocked behind its buffer stalls the following ALU word
        rst_assert();
        rst_release();
        ALUbuffer_ready = 1'b1;
        BRbuffer_ready  = 1'b0;
        push(W_ADD, 1'b0, 32'd1, 1'b1);
        push(W_BEQ, 1'b1, 32'd2, 1'b1);
        push(W_LW,  1'b0, 32'd3, 1'b1);
        repeat (3) tick();
        check("t3_held_level", {28'd0, q_level}, 32'd2);
        check("t3_held_sb", sb.size(), 32'd2);
        BRbuffer_ready = 1'b1;
        wait_drain(cyc);

        // T4: fill all 8 entries, then drain back to back
        rst_assert();
        rst_release();
        ALUbuffer_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(W_ADD + 32'(i), 1'b0, 32'(i), 1'b1);
        check("t4_full_ready", {31'd0, IF_Ready}, 32'd0);
        check("t4_full_level", {28'd0, q_level}, 32'd8);
        ALUbuffer_ready = 1'b1;
        wait_drain(cyc);
        // First negedge precedes the first dispatching edge, then one per pop.
        check("t4_drain_cycles", 32'(cyc), 32'd9);

        // T5a: NOP between two ALU words is dropped and takes no number
        rst_assert();
        rst_release();
        ALUbuffer_ready = 1'b1;
        push(W_ADD,        1'b0, 32'd1, 1'b1);
        push(32'h0000_0000, 1'b0, 32'd0, 1'b0);
        push(W_LW,         1'b0, 32'd2, 1'b1);
        wait_drain(cyc);

        // T5b: flush with 3 queued; same-edge fetch and dispatch suppressed
        rst_assert();
        rst_release();
        ALUbuffer_ready = 1'b0;
        push(W_ADD, 1'b0, 32'd1, 1'b0);
        push(W_BEQ, 1'b1, 32'd2, 1'b0);
        push(W_LW,  1'b0, 32'd3, 1'b0);
        check("t5_level_pre_flush", {28'd0, q_level}, 32'd3);
        flush = 1'b1;
        ALUbuffer_ready = 1'b1;
        IF_Instr = W_LW;
        IF_Valid = 1'b1;
        tick();
        flush = 1'b0;
        IF_Valid = 1'b0;
        check("t5_level_post_flush", {28'd0, q_level}, 32'd0);
        check("t5_alu_dr_post_flush", {31'd0, ALU_DR}, 32'd0);
        repeat (2) tick();
        push(W_ADD, 1'b0, 32'd4, 1'b1);
        wait_drain(cyc);

        // T6: number wrap on the second instance
        rst_assert();
        rst_release();
        check("t6_ready", {31'd0, IF_Ready1}, 32'd1);
        sb1.push_back('{1'b0, W_ADD, 32'hFFFF_FFFF});
        sb1.push_back('{1'b1, W_BEQ, 32'h0000_0000});
        IF_Instr1 = W_ADD;
        IF_Valid1 = 1'b1;
        tick();
        IF_Instr1 = W_BEQ;
        tick();
        IF_Valid1 = 1'b0;
        cyc = 0;
        while (sb1.size() != 0 && cyc < 50) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("t6_drain_left", sb1.size(), 32'd0);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
